// File: rtl/sonar_ctrl_pkg.sv
// rtl/sonar_ctrl_pkg.sv - shared types and constants for the sonar capture sequencer
package sonar_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ALIGN   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_WAIT    = 2'd3
   } state_t;

   // Microphone slot carried on tuser; a sample set always begins at MIC_LL.
   localparam logic [1:0] MIC_LL = 2'd0;
   localparam logic [1:0] MIC_LH = 2'd1;
   localparam logic [1:0] MIC_RL = 2'd2;
   localparam logic [1:0] MIC_RH = 2'd3;

   localparam int SET_BEATS = 4;

endpackage

// File: rtl/sonar_ping_timer.sv
// rtl/sonar_ping_timer.sv - ping period timer, ping-length counter and expiry strobe
module sonar_ping_timer
   import sonar_ctrl_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             active,
   input  logic             ping_evt,
   input  logic [CNT_W-1:0] period,
   input  logic [LEN_W-1:0] ping_len,
   output logic             expire,
   output logic             ping_out
);

   logic [CNT_W-1:0] period_m1;
   logic [CNT_W-1:0] timer;
   logic [LEN_W-1:0] ping_rem;

   // Expiry and wrap share one compare; the sequencer decides whether it becomes a ping.
   assign expire = active && (timer == period_m1);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         period_m1 <= '0;
         timer     <= '0;
         ping_rem  <= '0;
         ping_out  <= 1'b0;
      end else begin
         if (ping_evt) begin
            period_m1 <= (period == '0) ? '0 : period - CNT_W'(1);
            timer     <= '0;
         end else if (active) begin
            timer <= expire ? '0 : timer + CNT_W'(1);
         end else begin
            timer <= '0;
         end

         // ping_rem counts the high cycles still owed after the current one.
         if (ping_evt) begin
            ping_rem <= (ping_len == '0) ? '0 : ping_len - LEN_W'(1);
            ping_out <= 1'b1;
         end else begin
            ping_out <= (ping_rem != '0);
            if (ping_rem != '0)
               ping_rem <= ping_rem - LEN_W'(1);
         end
      end
   end

endmodule

// File: rtl/sonar_capture_ctrl.sv
// rtl/sonar_capture_ctrl.sv - ping scheduler and aligned capture window between I2S front end and DMA
module sonar_capture_ctrl
   import sonar_ctrl_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int LEN_W = 16
) (
   input  logic             m_axis_aclk,
   input  logic             m_axis_aresetn,
   input  logic             start,
   input  logic             run,
   input  logic [CNT_W-1:0] period,
   input  logic [LEN_W-1:0] ping_len,
   input  logic [LEN_W-1:0] capture_len,
   output logic             ping_out,
   output logic             busy,
   output logic             overrun,
   input  logic [31:0]      s_axis_tdata,
   input  logic [1:0]       s_axis_tuser,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic [31:0]      m_axis_tdata,
   output logic [1:0]       m_axis_tuser,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast
);

   localparam int BEAT_W = LEN_W + 2;

   state_t            state;
   logic [BEAT_W-1:0] beat_cnt;
   logic [BEAT_W-1:0] last_beat;
   logic [LEN_W-1:0]  cap_nz;
   logic              ping_evt;
   logic              expire;
   logic              handshake;
   logic              at_last;
   logic              set_start;

   assign cap_nz    = (capture_len == '0) ? LEN_W'(1) : capture_len;
   assign handshake = s_axis_tvalid && m_axis_tready;
   assign at_last   = (beat_cnt == last_beat);
   assign set_start = s_axis_tvalid && (s_axis_tuser == MIC_LL);
   assign busy      = (state != ST_IDLE);

   // A slot expiring while a packet is still open is an overrun, never a ping.
   assign ping_evt = ((state == ST_IDLE) && (start || run)) ||
                     ((state == ST_WAIT) && run && expire);

   sonar_ping_timer #(
      .CNT_W (CNT_W),
      .LEN_W (LEN_W)
   ) u_timer (
      .clk      (m_axis_aclk),
      .resetn   (m_axis_aresetn),
      .active   (busy),
      .ping_evt (ping_evt),
      .period   (period),
      .ping_len (ping_len),
      .expire   (expire),
      .ping_out (ping_out)
   );

   always_ff @(posedge m_axis_aclk) begin
      if (!m_axis_aresetn) begin
         state     <= ST_IDLE;
         beat_cnt  <= '0;
         last_beat <= '0;
         overrun   <= 1'b0;
      end else begin
         if (expire && ((state == ST_ALIGN) || (state == ST_CAPTURE)))
            overrun <= 1'b1;
         if (ping_evt)
            last_beat <= BEAT_W'(cap_nz) * BEAT_W'(SET_BEATS) - BEAT_W'(1);

         case (state)
            ST_IDLE: begin
               if (ping_evt)
                  state <= ST_ALIGN;
            end
            ST_ALIGN: begin
               beat_cnt <= '0;
               if (set_start)
                  state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               if (handshake) begin
                  beat_cnt <= beat_cnt + BEAT_W'(1);
                  if (at_last)
                     state <= run ? ST_WAIT : ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (!run)
                  state <= ST_IDLE;
               else if (ping_evt)
                  state <= ST_ALIGN;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The first MIC_LL beat is held in ALIGN so it re-presents as the first packet beat.
   always_comb begin
      s_axis_tready = 1'b1;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      case (state)
         ST_ALIGN: s_axis_tready = !set_start;
         ST_CAPTURE: begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = at_last;
         end
         default: ;
      endcase
   end

   assign m_axis_tdata = s_axis_tdata;
   assign m_axis_tuser = s_axis_tuser;

endmodule

// File: tb/tb_sonar_capture_ctrl.sv
// tb/tb_sonar_capture_ctrl.sv - directed scoreboard bench for sonar_capture_ctrl
module tb_sonar_capture_ctrl;
   import sonar_ctrl_pkg::*;

   localparam int CNT_W = 32;
   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             resetn, start, run;
   logic [CNT_W-1:0] period;
   logic [LEN_W-1:0] ping_len, capture_len;
   logic             ping_out, busy, overrun;
   logic [31:0]      s_tdata, m_tdata;
   logic [1:0]       s_tuser, m_tuser;
   logic             s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;

   always #5 clk = ~clk;

   sonar_capture_ctrl #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
      .m_axis_aclk    (clk),
      .m_axis_aresetn (resetn),
      .start          (start),
      .run            (run),
      .period         (period),
      .ping_len       (ping_len),
      .capture_len    (capture_len),
      .ping_out       (ping_out),
      .busy           (busy),
      .overrun        (overrun),
      .s_axis_tdata   (s_tdata),
      .s_axis_tuser   (s_tuser),
      .s_axis_tvalid  (s_tvalid),
      .s_axis_tready  (s_tready),
      .m_axis_tdata   (m_tdata),
      .m_axis_tuser   (m_tuser),
      .m_axis_tvalid  (m_tvalid),
      .m_axis_tready  (m_tready),
      .m_axis_tlast   (m_tlast)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Microphone source: holds each beat until taken, tuser cycles through the four slots.
   bit src_on = 0;
   bit bp_en  = 0;
   int src_idle_pct = 0;
   int src_seq = 0;
   bit src_taken = 0;

   always @(posedge clk) begin
      #1;
      if (!s_tvalid || src_taken) begin
         if (!src_on || ($urandom_range(99) < src_idle_pct)) begin
            s_tvalid = 1'b0;
         end else begin
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            s_tuser  = src_seq[1:0];
            src_seq++;
         end
      end
      m_tready = bp_en ? 1'($urandom_range(1)) : 1'b1;
   end

   // Reference model of the sequencer, driven only by bench-side inputs.
   typedef enum int {M_IDLE, M_ALIGN, M_CAP, M_WAIT} mst_t;
   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  u;
      logic        l;
   } beat_t;

   mst_t        mst = M_IDLE;
   int unsigned tmr = 0, per_m1 = 0, prem = 0, beats_m1 = 0, cnt = 0;
   bit          exp_ovr = 0;
   beat_t       sb_q[$];
   bit          chk_en = 0;
   int          cyc = 0, out_beats = 0, pkts = 0, ping_hi = 0, disc = 0, pkt_idx = 0;
   int          rise_t[$];
   logic        ping_d = 1'b0;

   always @(negedge clk) begin
      bit    ev, expd, hs_out, exp_rdy;
      mst_t  nxt;
      beat_t b, e;
      cyc++;
      src_taken = s_tvalid && s_tready;
      hs_out    = m_tvalid && m_tready;
      expd      = (mst != M_IDLE) && (tmr == per_m1);
      exp_rdy   = (mst == M_ALIGN) ? !(s_tvalid && s_tuser == MIC_LL) :
                  (mst == M_CAP)   ? m_tready : 1'b1;
      ev  = 0;
      nxt = mst;

      if (mst == M_CAP && s_tvalid && m_tready) begin
         e.d = s_tdata;
         e.u = s_tuser;
         e.l = (cnt == beats_m1);
         sb_q.push_back(e);
      end

      if (chk_en) begin
         check("busy", busy, mst != M_IDLE);
         check("ping_out", ping_out, prem != 0);
         check("overrun", overrun, exp_ovr);
         check("m_tvalid", m_tvalid, (mst == M_CAP) ? s_tvalid : 1'b0);
         check("s_tready", s_tready, exp_rdy);
         if (mst != M_CAP) check("m_tlast_outside", m_tlast, 1'b0);
         if (m_tvalid) begin
            check("pt_tdata", m_tdata, s_tdata);
            check("pt_tuser", m_tuser, s_tuser);
         end
         if (hs_out) begin
            check("sb_nonempty", sb_q.size() > 0, 1'b1);
            check("tuser_order", m_tuser, pkt_idx[1:0]);
            if (sb_q.size() > 0) begin
               b = sb_q.pop_front();
               check("sb_tdata", m_tdata, b.d);
               check("sb_tuser", m_tuser, b.u);
               check("sb_tlast", m_tlast, b.l);
            end
         end
      end

      if (hs_out) begin
         out_beats++;
         if (m_tlast) begin pkts++; pkt_idx = 0; end
         else pkt_idx++;
      end
      if (ping_out === 1'b1) ping_hi++;
      if (ping_out === 1'b1 && ping_d !== 1'b1) rise_t.push_back(cyc);
      ping_d = ping_out;
      if (busy === 1'b1 && src_taken && !hs_out) disc++;

      if (!resetn) begin
         mst = M_IDLE; tmr = 0; prem = 0; cnt = 0; exp_ovr = 0; pkt_idx = 0;
         sb_q.delete();
      end else begin
         if (mst == M_IDLE) begin
            if (start || run) ev = 1;
         end else if (mst == M_WAIT) begin
            if (!run) nxt = M_IDLE;
            else if (expd) ev = 1;
         end else if (expd) begin
            exp_ovr = 1;
         end
         if (mst == M_ALIGN && s_tvalid && s_tuser == MIC_LL) nxt = M_CAP;
         if (mst == M_CAP && s_tvalid && m_tready) begin
            if (cnt == beats_m1) nxt = run ? M_WAIT : M_IDLE;
            cnt++;
         end
         if (ev) begin
            nxt      = M_ALIGN;
            per_m1   = (period == 0) ? 0 : period - 1;
            beats_m1 = 4 * ((capture_len == 0) ? 1 : capture_len) - 1;
            prem     = (ping_len == 0) ? 1 : ping_len;
            tmr      = 0;
            cnt      = 0;
         end else begin
            if (prem != 0) prem--;
            if (mst != M_IDLE) tmr = expd ? 0 : tmr + 1;
         end
         mst = nxt;
      end
   end

   task automatic clear_stats();
      out_beats = 0; pkts = 0; ping_hi = 0; disc = 0;
      rise_t.delete();
   endtask

   task automatic pulse_start();
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      @(negedge clk);
      while ((busy || ping_out) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, n < budget, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ping_out"}, ping_out, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_overrun"}, overrun, 1'b0);
      check({tag, "_m_tvalid"}, m_tvalid, 1'b0);
      check({tag, "_m_tlast"}, m_tlast, 1'b0);
      check({tag, "_s_tready"}, s_tready, 1'b1);
   endtask

   initial begin
      int n;
      resetn = 1'b0; start = 1'b0; run = 1'b0;
      period = 32'd1000; ping_len = 16'd50; capture_len = 16'd3;
      m_tready = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0;
      repeat (3) @(posedge clk);
      #2 resetn = 1'b1; chk_en = 1;
      @(negedge clk);
      check_reset_outputs("reset");

      // Single shot, stream entering ALIGN at tuser 2.
      clear_stats();
      @(posedge clk); #2 start = 1'b1; src_seq = 2; src_on = 1;
      @(posedge clk); #2 start = 1'b0;
      wait_done(300, "single");
      check("single_discards", disc, 2);
      check("single_beats", out_beats, 12);
      check("single_pkts", pkts, 1);
      check("single_ping_len", ping_hi, 50);

      // Periodic pings.
      clear_stats();
      period = 32'd2000; capture_len = 16'd2; ping_len = 16'd20;
      @(posedge clk); #2 run = 1'b1;
      repeat (6500) @(posedge clk);
      #2 run = 1'b0;
      wait_done(3000, "periodic");
      check("periodic_rises", rise_t.size(), 4);
      for (int i = 1; i < rise_t.size(); i++)
         check("periodic_interval", rise_t[i] - rise_t[i-1], 2000);
      check("periodic_pkts", pkts, 4);
      check("periodic_beats", out_beats, 32);
      check("periodic_overrun", overrun, 1'b0);

      // Random backpressure and source gaps.
      clear_stats();
      period = 32'd1000; capture_len = 16'd8; ping_len = 16'd4;
      bp_en = 1; src_idle_pct = 30;
      pulse_start();
      wait_done(600, "bp");
      bp_en = 0; src_idle_pct = 0;
      check("bp_beats", out_beats, 32);
      check("bp_pkts", pkts, 1);

      // Slow source forces expiry during CAPTURE.
      clear_stats();
      period = 32'd100; capture_len = 16'd64; ping_len = 16'd10;
      src_idle_pct = 75;
      @(posedge clk); #2 run = 1'b1;
      repeat (1500) @(posedge clk);
      #2 run = 1'b0;
      wait_done(3000, "overrun");
      src_idle_pct = 0;
      check("overrun_flag", overrun, 1'b1);
      check("overrun_pkts", pkts, 2);
      check("overrun_beats", out_beats, 512);
      check("overrun_rises", rise_t.size(), 2);
      if (rise_t.size() >= 2)
         check("overrun_slot_align", (rise_t[1] - rise_t[0]) % 100, 0);

      // Dropping run mid-packet.
      clear_stats();
      period = 32'd500; capture_len = 16'd16; ping_len = 16'd5;
      @(posedge clk); #2 run = 1'b1;
      repeat (20) @(posedge clk);
      #2 run = 1'b0;
      wait_done(400, "stop");
      check("stop_pkts", pkts, 1);
      check("stop_beats", out_beats, 64);

      // Zero-valued settings.
      clear_stats();
      period = '0; capture_len = '0; ping_len = '0;
      pulse_start();
      wait_done(100, "zero");
      check("zero_beats", out_beats, 4);
      check("zero_pkts", pkts, 1);
      check("zero_ping_len", ping_hi, 1);

      // Reset in the middle of a packet.
      clear_stats();
      period = 32'd1000; capture_len = 16'd3; ping_len = 16'd50;
      pulse_start();
      n = 0;
      while (out_beats < 5 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("midrst_wait", n < 100, 1'b1);
      @(posedge clk); #2 resetn = 1'b0;
      @(posedge clk); #2 resetn = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrst");
      clear_stats();
      pulse_start();
      wait_done(300, "post_rst");
      check("post_rst_beats", out_beats, 12);
      check("post_rst_pkts", pkts, 1);

      check("sb_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
